// File: rtl/pad_bank_arbiter_pkg.sv
// Shared types for the pad bank arbiter: FSM state encoding and turnaround counter width.
package pad_bank_arbiter_pkg;

   localparam int TURN_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/pad_bank_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, scanning upward with wrap.
module rr_pick #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         gnt_oh,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any
);

   localparam int IDXW = $clog2(NREQ);

   always_comb begin
      gnt_oh = '0;
      idx    = '0;
      any    = 1'b0;
      // Outer loop walks priority order from ptr; inner loop keeps every index constant.
      for (int i = 0; i < NREQ; i++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!any && req[j] && (j == ((int'(ptr) + i) % NREQ))) begin
               any       = 1'b1;
               gnt_oh[j] = 1'b1;
               idx       = IDXW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/pad_bank_arbiter.sv
// Exclusive round-robin owner of one shared pad bank, with an all-OE-low turnaround between owners.
// Optional forced release after MAX_HOLD cycles under contention: define PAD_ARB_TIMEOUT_EN.
module pad_bank_arbiter
   import pad_bank_arbiter_pkg::*;
#(
   parameter int                  NREQ         = 3,
   parameter int                  NPADS        = 4,
   parameter int                  PAD_ATTR     = 16,
   parameter int                  TURN_CYCLES  = 2,
   parameter logic [PAD_ATTR-1:0] DEFAULT_ATTR = '0,
   parameter int                  MAX_HOLD     = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NREQ-1:0]           req_i,
   output logic [NREQ-1:0]           gnt_o,
   input  logic [NREQ*NPADS-1:0]     out_i,
   input  logic [NREQ*NPADS-1:0]     oe_i,
   input  logic [NREQ*PAD_ATTR-1:0]  attr_i,
   output logic [NPADS-1:0]          in_o,
   output logic [NPADS-1:0]          pad_in_o,
   output logic [NPADS-1:0]          pad_oe_o,
   input  logic [NPADS-1:0]          pad_out_i,
   output logic [PAD_ATTR-1:0]       pad_attributes_o,
   output logic [$clog2(NREQ)-1:0]   owner_o,
   output logic                      busy_o,
   output logic                      timeout_o
);

   localparam int IDXW = $clog2(NREQ);
   localparam logic [TURN_W-1:0] TURN_LOAD =
      (TURN_CYCLES > 0) ? TURN_W'(TURN_CYCLES - 1) : '0;

   // req/gnt handshake: req_i is a level held for as long as the requester wants the bank;
   // gnt_o rises one edge after winning and falls on the edge where req_i is seen low
   // (or on a forced release). A requester drives the pads only while its gnt_o is high.

   arb_state_e          state_q, state_d;
   logic [IDXW-1:0]     owner_q, owner_d;
   logic [IDXW-1:0]     ptr_q, ptr_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic [TURN_W-1:0]   turn_q, turn_d;
   logic [PAD_ATTR-1:0] attr_q, attr_sel;
   logic [IDXW-1:0]     ptr_after, pick_ptr, pick_idx;
   logic [NREQ-1:0]     pick_oh;
   logic                pick_any, busy, owner_req, timeout_fire;

   assign busy      = (state_q == ST_GRANT);
   assign owner_req = |(req_i & gnt_q);
   assign ptr_after = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
   // While granted, the picker already sees the post-release pointer so a zero-length
   // turnaround can re-arbitrate on the release edge.
   assign pick_ptr  = busy ? ptr_after : ptr_q;

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .req    (req_i),
      .ptr    (pick_ptr),
      .gnt_oh (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      turn_d  = turn_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d = ST_GRANT;
               owner_d = pick_idx;
               gnt_d   = pick_oh;
            end
         end
         ST_GRANT: begin
            if (!owner_req || timeout_fire) begin
               ptr_d = ptr_after;
               gnt_d = '0;
               if (TURN_CYCLES == 0) begin
                  if (pick_any) begin
                     owner_d = pick_idx;
                     gnt_d   = pick_oh;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_TURN;
                  turn_d  = TURN_LOAD;
               end
            end
         end
         ST_TURN: begin
            if (turn_q == '0) begin
               if (pick_any) begin
                  state_d = ST_GRANT;
                  owner_d = pick_idx;
                  gnt_d   = pick_oh;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               turn_d = turn_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         turn_q  <= '0;
         attr_q  <= DEFAULT_ATTR;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         turn_q  <= turn_d;
         attr_q  <= busy ? attr_sel : attr_q;
      end
   end

   // gnt_q is all-zero outside GRANT, so the pad drive falls to zero without a state test.
   always_comb begin
      pad_in_o = '0;
      pad_oe_o = '0;
      attr_sel = '0;
      for (int r = 0; r < NREQ; r++) begin
         if (gnt_q[r]) begin
            pad_in_o = out_i[r*NPADS +: NPADS];
            pad_oe_o = oe_i[r*NPADS +: NPADS];
            attr_sel = attr_i[r*PAD_ATTR +: PAD_ATTR];
         end
      end
   end

`ifdef PAD_ARB_TIMEOUT_EN
   localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

   logic [HOLD_W-1:0] hold_q;
   logic              others_req, timeout_q;

   assign others_req   = |(req_i & ~gnt_q);
   assign timeout_fire = busy && (hold_q == HOLD_W'(MAX_HOLD - 1)) && others_req;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_fire;
         if ((gnt_d != '0) && (gnt_d != gnt_q)) begin
            hold_q <= '0;
         end else if (busy && (hold_q != HOLD_W'(MAX_HOLD - 1))) begin
            hold_q <= hold_q + 1'b1;
         end
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_fire = 1'b0;
   assign timeout_o    = 1'b0;
`endif

   assign gnt_o            = gnt_q;
   assign owner_o          = owner_q;
   assign busy_o           = busy;
   assign in_o             = pad_out_i;
   assign pad_attributes_o = busy ? attr_sel : attr_q;

endmodule

// File: tb/tb_pad_bank_arbiter.sv
// Bench for pad_bank_arbiter: directed table, idle/rotation/hold sequences, and randomized
// traffic checked against an ownership model. Covers PAD_ARB_TIMEOUT_EN defined or not.
module tb_pad_bank_arbiter;

   localparam int          NREQ        = 3;
   localparam int          NPADS       = 4;
   localparam int          PAD_ATTR    = 16;
   localparam int          TURN_CYCLES = 2;
   localparam int          MAX_HOLD    = 8;
   localparam logic [15:0] DEF_ATTR    = 16'hD00D;
`ifdef PAD_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic [11:0] out_v, oe_v;
   logic [47:0] attr_v;
   logic [3:0]  pad_out;
   logic [2:0]  gnt;
   logic [3:0]  in_w, pad_in, pad_oe;
   logic [15:0] attr_o;
   logic [1:0]  owner;
   logic        busy, timeout;

   always #5 clk = ~clk;

   pad_bank_arbiter #(
      .NREQ(NREQ), .NPADS(NPADS), .PAD_ATTR(PAD_ATTR), .TURN_CYCLES(TURN_CYCLES),
      .DEFAULT_ATTR(DEF_ATTR), .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .out_i(out_v), .oe_i(oe_v),
      .attr_i(attr_v), .in_o(in_w), .pad_in_o(pad_in), .pad_oe_o(pad_oe),
      .pad_out_i(pad_out), .pad_attributes_o(attr_o), .owner_o(owner), .busy_o(busy),
      .timeout_o(timeout)
   );

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- ownership model ----------------
   int          m_owner = -1;  // -1: nobody owns the bank
   int          m_turn  = 0;   // turnaround cycles still to run
   int          m_ptr   = 0;
   int          m_hold  = 0;
   int          m_age   = 0;
   bit          m_to    = 1'b0;
   logic [15:0] m_attr  = DEF_ATTR;

   task automatic model_arbitrate();
      for (int i = 0; i < NREQ; i++) begin
         int j;
         j = (m_ptr + i) % NREQ;
         if (m_owner < 0 && req[j]) begin
            m_owner = j;
            m_hold  = 0;
            m_age   = 0;
         end
      end
   endtask

   task automatic model_step();
      bit others, forced;
      m_to = 1'b0;
      if (!rst_n) begin
         m_owner = -1; m_turn = 0; m_ptr = 0; m_hold = 0; m_age = 0; m_attr = DEF_ATTR;
      end else if (m_owner >= 0) begin
         others = (req & ~(3'(1 << m_owner))) != 3'b000;
         forced = TO_EN && (m_hold == MAX_HOLD - 1) && others;
         if (!req[m_owner] || forced) begin
            m_to   = forced;
            m_attr = 16'(attr_v >> (m_owner * PAD_ATTR));
            m_ptr  = (m_owner + 1) % NREQ;
            m_owner = -1;
            if (TURN_CYCLES == 0) model_arbitrate();
            else m_turn = TURN_CYCLES;
         end else begin
            if (m_hold < MAX_HOLD - 1) m_hold++;
            m_age++;
         end
      end else if (m_turn > 0) begin
         m_turn--;
         if (m_turn == 0) model_arbitrate();
      end else begin
         model_arbitrate();
      end
   endtask

   task automatic model_check();
      logic [2:0]  eg;
      logic [3:0]  eoe, ein;
      logic [15:0] ea;
      if (m_owner >= 0) begin
         eg  = 3'(1 << m_owner);
         eoe = 4'(oe_v >> (m_owner * NPADS));
         ein = 4'(out_v >> (m_owner * NPADS));
         ea  = 16'(attr_v >> (m_owner * PAD_ATTR));
         check("m_owner", 32'(owner), 32'(m_owner));
      end else begin
         eg = '0; eoe = '0; ein = '0; ea = m_attr;
      end
      check("m_gnt", 32'(gnt), 32'(eg));
      check("m_busy", 32'(busy), 32'(m_owner >= 0));
      check("m_pad_oe", 32'(pad_oe), 32'(eoe));
      check("m_pad_in", 32'(pad_in), 32'(ein));
      check("m_attr", 32'(attr_o), 32'(ea));
      check("m_in_o", 32'(in_w), 32'(pad_out));
      check("m_timeout", 32'(timeout), 32'(m_to && TO_EN));
      check("m_gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
   endtask

   // One clock: model follows the edge, outputs sampled 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      model_check();
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        rst_n;
      logic [2:0]  req;
      logic [3:0]  pad_out;
      logic [2:0]  gnt;
      logic        busy;
      logic [1:0]  owner;
      logic [3:0]  oe;
      logic [3:0]  pin;
      logic [15:0] attr;
   } vec_t;

   vec_t        vecs[16];
   logic [1:0]  exp_q[$];
   logic [1:0]  act_q[$];
   logic [2:0]  prev_gnt;
   int          cnt;
   logic        seen_to;

   initial begin
      vecs[0]  = '{1'b0, 3'b000, 4'h1, 3'b000, 1'b0, 2'd0, 4'h0, 4'h0, 16'hD00D};
      vecs[1]  = '{1'b1, 3'b000, 4'h2, 3'b000, 1'b0, 2'd0, 4'h0, 4'h0, 16'hD00D};
      vecs[2]  = '{1'b1, 3'b001, 4'h3, 3'b001, 1'b1, 2'd0, 4'hF, 4'hA, 16'hBEEF};
      vecs[3]  = '{1'b1, 3'b101, 4'h4, 3'b001, 1'b1, 2'd0, 4'hF, 4'hA, 16'hBEEF};
      vecs[4]  = '{1'b1, 3'b100, 4'h5, 3'b000, 1'b0, 2'd0, 4'h0, 4'h0, 16'hBEEF};
      vecs[5]  = '{1'b1, 3'b100, 4'h6, 3'b000, 1'b0, 2'd0, 4'h0, 4'h0, 16'hBEEF};
      vecs[6]  = '{1'b1, 3'b100, 4'h7, 3'b100, 1'b1, 2'd2, 4'hC, 4'h3, 16'h2222};
      vecs[7]  = '{1'b1, 3'b110, 4'h8, 3'b100, 1'b1, 2'd2, 4'hC, 4'h3, 16'h2222};
      vecs[8]  = '{1'b1, 3'b010, 4'h9, 3'b000, 1'b0, 2'd0, 4'h0, 4'h0, 16'h2222};
      vecs[9]  = '{1'b1, 3'b011, 4'hA, 3'b000, 1'b0, 2'd0, 4'h0, 4'h0, 16'h2222};
      vecs[10] = '{1'b1, 3'b011, 4'hB, 3'b001, 1'b1, 2'd0, 4'hF, 4'hA, 16'hBEEF};
      vecs[11] = '{1'b0, 3'b011, 4'hC, 3'b000, 1'b0, 2'd0, 4'h0, 4'h0, 16'hD00D};
      vecs[12] = '{1'b1, 3'b011, 4'hD, 3'b001, 1'b1, 2'd0, 4'hF, 4'hA, 16'hBEEF};
      vecs[13] = '{1'b1, 3'b010, 4'hE, 3'b000, 1'b0, 2'd0, 4'h0, 4'h0, 16'hBEEF};
      vecs[14] = '{1'b1, 3'b011, 4'hF, 3'b000, 1'b0, 2'd0, 4'h0, 4'h0, 16'hBEEF};
      vecs[15] = '{1'b1, 3'b011, 4'h0, 3'b010, 1'b1, 2'd1, 4'h6, 4'h5, 16'h1111};

      rst_n   = 1'b0;
      req     = 3'b000;
      out_v   = 12'h35A;
      oe_v    = 12'hC6F;
      attr_v  = {16'h2222, 16'h1111, 16'hBEEF};
      pad_out = 4'h0;

      // Reset values, then 10 idle cycles with no requests.
      cycle();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_pad_oe", 32'(pad_oe), 32'd0);
      check("rst_pad_in", 32'(pad_in), 32'd0);
      check("rst_attr", 32'(attr_o), 32'(DEF_ATTR));
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         cycle();
         check("idle_gnt", 32'(gnt), 32'd0);
         check("idle_pad_oe", 32'(pad_oe), 32'd0);
         check("idle_attr", 32'(attr_o), 32'(DEF_ATTR));
      end

      // Table: grant, turnaround, RR pointer, mid-grant reset, re-request losing to RR order.
      for (int v = 0; v < 16; v++) begin
         rst_n   = vecs[v].rst_n;
         req     = vecs[v].req;
         pad_out = vecs[v].pad_out;
         cycle();
         check($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vecs[v].gnt));
         check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
         if (vecs[v].busy || !vecs[v].rst_n)
            check($sformatf("vec%0d_owner", v), 32'(owner), 32'(vecs[v].owner));
         check($sformatf("vec%0d_pad_oe", v), 32'(pad_oe), 32'(vecs[v].oe));
         check($sformatf("vec%0d_pad_in", v), 32'(pad_in), 32'(vecs[v].pin));
         check($sformatf("vec%0d_attr", v), 32'(attr_o), 32'(vecs[v].attr));
         check($sformatf("vec%0d_in_o", v), 32'(in_w), 32'(vecs[v].pad_out));
      end

      // Rotation: all requesting, each owner lets go after 4 granted cycles.
      rst_n = 1'b0; req = 3'b000; cycle();
      rst_n = 1'b1;
      prev_gnt = 3'b000;
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd0};
      for (int c = 0; c < 24; c++) begin
         req = 3'b111;
         if (m_owner >= 0 && m_age == 3) req[m_owner] = 1'b0;
         cycle();
         if (gnt != 3'b000 && prev_gnt == 3'b000)
            for (int k = 0; k < NREQ; k++) if (gnt[k]) act_q.push_back(2'(k));
         prev_gnt = gnt;
      end
      check("rot_count", 32'(act_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
         check($sformatf("rot_order%0d", i), 32'(act_q[i]), 32'(exp_q[i]));

      // Long hold by requester 0 with requester 1 pending.
      rst_n = 1'b0; req = 3'b000; cycle();
      rst_n = 1'b1; req = 3'b001; cycle();
      cnt = (gnt == 3'b001) ? 1 : 0;
      req = 3'b011;
      seen_to = 1'b0;
`ifdef PAD_ARB_TIMEOUT_EN
      for (int c = 0; c < 20; c++) begin
         cycle();
         if (gnt == 3'b001) cnt++;
         else begin
            seen_to = timeout;
            break;
         end
      end
      check("hold_cycles", 32'(cnt), 32'(MAX_HOLD));
      check("timeout_pulse", 32'(seen_to), 32'd1);
      cycle();
      check("timeout_width", 32'(timeout), 32'd0);
      check("timeout_turn_gnt", 32'(gnt), 32'd0);
      cycle();
      check("timeout_next_gnt", 32'(gnt), 32'b010);
`else
      for (int c = 0; c < 40; c++) begin
         cycle();
         check("keep_grant", 32'(gnt), 32'b001);
         check("keep_no_timeout", 32'(timeout), 32'd0);
      end
`endif

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
         out_v   = 12'($urandom);
         oe_v    = 12'($urandom);
         attr_v  = 48'({$urandom, $urandom});
         pad_out = 4'($urandom);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
